pll_lock_supervisor: RTL and testbench

- Controls and consumes the Tang9K rPLL. Drives the PLL RESET input, qualifies the asynchronous LOCK output, and generates the active-high system reset for PLL-clocked logic.
- Retries lock acquisition a bounded number of times, then latches a fault.
- Sits beside the 27 MHz-to-72 MHz PLL wrapper and is clocked from the free-running 27 MHz crystal (clkin), never from the PLL output.

---
 rtl/pll_lock_supervisor_pkg.sv | 25 ++
 rtl/pll_lock_supervisor_if.sv | 25 ++
 rtl/pll_lock_supervisor_sync_bit.sv | 18 +
 rtl/pll_lock_supervisor.sv | 128 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and sizing helpers for the rPLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int LOCK_LOSS_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Keeps counters at least one bit wide for degenerate parameter choices.
  function automatic int clog2_min1(input int v);
    return (v > 2) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Lock/control/status bundle between the supervisor and its PLL/system neighbours.
interface pll_lock_supervisor_if
  import pll_sup_pkg::*;
#(
  parameter int RC_W = 2
) ();
  logic                   pll_locked_async;
  logic                   sw_restart;
  logic                   pll_reset;
  logic                   sys_rst;
  logic                   ready;
  logic                   fault;
  logic [RC_W-1:0]        retry_count;
  logic [LOCK_LOSS_W-1:0] lock_loss_count;

  modport master (
    input  pll_locked_async, sw_restart,
    output pll_reset, sys_rst, ready, fault, retry_count, lock_loss_count
  );

  modport slave (
    output pll_locked_async, sw_restart,
    input  pll_reset, sys_rst, ready, fault, retry_count, lock_loss_count
  );
endinterface

// File: rtl/pll_lock_supervisor_sync_bit.sv
// N-flop single-bit synchronizer; also usable for sys_rst deassert sync downstream.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences rPLL reset, qualifies LOCK and owns the system reset; clocked by the
// free-running crystal so it keeps running whatever the PLL does.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int PLL_RST_CYCLES = 16,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  pll_lock_supervisor_if.master  bus
);
  localparam int CNT_W = clog2_min1(max3(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES));
  localparam int RC_W  = clog2_min1(MAX_RETRIES + 1);

  pll_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RC_W-1:0]        rc_q, rc_d;
  logic [LOCK_LOSS_W-1:0] llc_q, llc_d;
  logic                   locked_s;
  logic                   pll_reset_q, sys_rst_q, ready_q, fault_q;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pll_locked_async),
    .q   (locked_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
      rc_q    <= '0;
      llc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      llc_q   <= llc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    rc_d    = rc_q;
    llc_d   = llc_q;
    if (bus.sw_restart) begin
      state_d = PLL_RST;
      cnt_d   = '0;
      rc_d    = '0;
    end else begin
      unique case (state_q)
        PLL_RST: begin
          if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        WAIT_LOCK: begin
          // Lock is checked before the timeout so a coincident lock still counts.
          if (locked_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            cnt_d = '0;
            if (rc_q < RC_W'(MAX_RETRIES)) begin
              rc_d    = rc_q + RC_W'(1);
              state_d = PLL_RST;
            end else begin
              state_d = FAULT;
            end
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            state_d = RUN;
            cnt_d   = '0;
            rc_d    = '0;
          end
        end
        RUN: begin
          cnt_d = '0;
          if (!locked_s) begin
            state_d = PLL_RST;
            if (llc_q != {LOCK_LOSS_W{1'b1}}) llc_d = llc_q + LOCK_LOSS_W'(1);
          end
        end
        FAULT: cnt_d = '0;
        default: begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs come from flops loaded with the next-state decode, so they track
  // the state register exactly without combinational decode glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      pll_reset_q <= (state_d == PLL_RST);
      sys_rst_q   <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign bus.pll_reset       = pll_reset_q;
  assign bus.sys_rst         = sys_rst_q;
  assign bus.ready           = ready_q;
  assign bus.fault           = fault_q;
  assign bus.retry_count     = rc_q;
  assign bus.lock_loss_count = llc_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed plus random checks of pll_lock_supervisor against a behavioural model.
module tb_pll_lock_supervisor;
  localparam int SS = 2, SC = 8, LT = 32, PRC = 4, MR = 2;
  localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FLT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0, n_bad = 0;
  bit   chk_en = 1'b0;

  pll_lock_supervisor_if #(.RC_W(2)) bus ();

  pll_lock_supervisor #(
    .SYNC_STAGES(SS), .STABLE_CYCLES(SC), .LOCK_TIMEOUT(LT),
    .PLL_RST_CYCLES(PRC), .MAX_RETRIES(MR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: lock history queue gives the SS-edge-delayed lock; phase/counter
  // follow the sequencing rules directly.
  int m_st = M_RST, m_cnt = 0, m_rc = 0, m_llc = 0;
  bit mq[$];
  bit ls;

  initial for (int i = 0; i < SS; i++) mq.push_back(1'b0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = M_RST; m_cnt = 0; m_rc = 0; m_llc = 0;
      mq.delete();
      for (int i = 0; i < SS; i++) mq.push_back(1'b0);
    end else begin
      ls = mq[0];
      void'(mq.pop_front());
      mq.push_back(bus.pll_locked_async);
      if (bus.sw_restart) begin
        m_st = M_RST; m_cnt = 0; m_rc = 0;
      end else if (m_st == M_RST) begin
        if (m_cnt == PRC - 1) begin m_st = M_WAIT; m_cnt = 0; end
        else m_cnt++;
      end else if (m_st == M_WAIT) begin
        if (ls) begin m_st = M_STAB; m_cnt = 0; end
        else if (m_cnt == LT - 1) begin
          m_cnt = 0;
          if (m_rc < MR) begin m_rc++; m_st = M_RST; end
          else m_st = M_FLT;
        end else m_cnt++;
      end else if (m_st == M_STAB) begin
        if (!ls) begin m_st = M_WAIT; m_cnt = 0; end
        else if (m_cnt == SC - 1) begin m_st = M_RUN; m_cnt = 0; m_rc = 0; end
        else m_cnt++;
      end else if (m_st == M_RUN) begin
        if (!ls) begin m_st = M_RST; m_cnt = 0; m_llc = (m_llc < 255) ? m_llc + 1 : 255; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc.pll_reset", 32'(bus.pll_reset), 32'(m_st == M_RST));
      chk("cyc.sys_rst",   32'(bus.sys_rst),   32'(m_st != M_RUN));
      chk("cyc.ready",     32'(bus.ready),     32'(m_st == M_RUN));
      chk("cyc.fault",     32'(bus.fault),     32'(m_st == M_FLT));
      chk("cyc.retry",     32'(bus.retry_count), 32'(m_rc));
      chk("cyc.llc",       32'(bus.lock_loss_count), 32'(m_llc));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart();
    bus.sw_restart = 1'b1;
    @(negedge clk);
    bus.sw_restart = 1'b0;
  endtask

  task automatic edges_to_release(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.sys_rst && n < 200);
  endtask

  task automatic wait_ready(input bit lvl, input int budget, output bit ok);
    int k = 0;
    while (bus.ready != lvl && k < budget) begin @(negedge clk); k++; end
    ok = (bus.ready == lvl);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pll_reset"}, 32'(bus.pll_reset), 32'd1);
    chk({tag, ".sys_rst"},   32'(bus.sys_rst),   32'd1);
    chk({tag, ".ready"},     32'(bus.ready),     32'd0);
    chk({tag, ".fault"},     32'(bus.fault),     32'd0);
    chk({tag, ".retry"},     32'(bus.retry_count), 32'd0);
    chk({tag, ".llc"},       32'(bus.lock_loss_count), 32'd0);
  endtask

  initial begin
    int n, hi, pulses, bad_to, dur;
    bit prev, ok, lvl;
    bus.pll_locked_async = 1'b0;
    bus.sw_restart       = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");
    chk_en = 1'b1;
    rst = 1'b0;

    // Reset then lock five cycles later
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.pll_reset) hi++;
      @(negedge clk);
    end
    chk("t1.pll_rst_width", 32'(hi), 32'd4);
    bus.pll_locked_async = 1'b1;
    edges_to_release(n);
    chk("t1.release_edges", 32'(n), 32'(SS + 1 + SC));
    chk("t1.ready", 32'(bus.ready), 32'd1);
    chk("t1.retry", 32'(bus.retry_count), 32'd0);

    // Never lock: three pulses then FAULT
    bus.pll_locked_async = 1'b0;
    restart();
    n = 0; hi = 0; pulses = 0; prev = 1'b0;
    while (!bus.fault && n < 300) begin
      if (bus.pll_reset) hi++;
      if (bus.pll_reset && !prev) pulses++;
      prev = bus.pll_reset;
      n++;
      @(negedge clk);
    end
    chk("t2.cycles_to_fault", 32'(n), 32'(3 * (PRC + LT)));
    chk("t2.pll_rst_cycles", 32'(hi), 32'(3 * PRC));
    chk("t2.pulses", 32'(pulses), 32'd3);
    step(40);
    chk("t2.fault", 32'(bus.fault), 32'd1);
    chk("t2.retry", 32'(bus.retry_count), 32'(MR));
    chk("t2.pll_reset", 32'(bus.pll_reset), 32'd0);
    chk("t2.sys_rst", 32'(bus.sys_rst), 32'd1);

    // sw_restart out of FAULT, then coincident with the final timeout
    restart();
    chk("t3.pll_reset", 32'(bus.pll_reset), 32'd1);
    chk("t3.fault", 32'(bus.fault), 32'd0);
    chk("t3.retry", 32'(bus.retry_count), 32'd0);
    step(3 * (PRC + LT) - 1);
    chk("t3.retry_pre", 32'(bus.retry_count), 32'(MR));
    restart();
    chk("t3b.fault", 32'(bus.fault), 32'd0);
    chk("t3b.pll_reset", 32'(bus.pll_reset), 32'd1);
    chk("t3b.retry", 32'(bus.retry_count), 32'd0);

    // Glitch in STABLE at cnt=5
    bus.pll_locked_async = 1'b1;
    restart();
    step(PRC + 1 + 5);
    bus.pll_locked_async = 1'b0;
    step(3);
    bus.pll_locked_async = 1'b1;
    edges_to_release(n);
    chk("t4.release_edges", 32'(n), 32'(SS + 1 + SC));
    chk("t4.retry", 32'(bus.retry_count), 32'd0);

    // Lock loss in RUN
    bus.pll_locked_async = 1'b0;
    n = 0;
    while (!bus.sys_rst && n < 20) begin @(negedge clk); n++; end
    chk("t5.loss_within3", 32'(n >= 1 && n <= 3), 32'd1);
    chk("t5.ready", 32'(bus.ready), 32'd0);
    chk("t5.llc", 32'(bus.lock_loss_count), 32'd1);
    bus.pll_locked_async = 1'b1;
    wait_ready(1'b1, 100, ok);
    chk("t5.relock_run", 32'(ok), 32'd1);

    // Drive loss events until well past saturation
    bad_to = 0;
    for (int i = 0; i < 299; i++) begin
      bus.pll_locked_async = 1'b0;
      @(negedge clk);
      bus.pll_locked_async = 1'b1;
      wait_ready(1'b0, 10, ok);
      if (!ok) bad_to++;
      wait_ready(1'b1, 100, ok);
      if (!ok) bad_to++;
    end
    chk("t6.timeouts", 32'(bad_to), 32'd0);
    chk("t6.llc_sat", 32'(bus.lock_loss_count), 32'd255);

    // Random lock activity with occasional sw_restart
    for (int s = 0; s < 120; s++) begin
      lvl = ($urandom_range(0, 9) < 7);
      dur = $urandom_range(1, 40);
      bus.pll_locked_async = lvl;
      for (int c = 0; c < dur; c++) begin
        bus.sw_restart = ($urandom_range(0, 99) == 0);
        @(negedge clk);
      end
      bus.sw_restart = 1'b0;
    end

    // Asynchronous reset between edges while in STABLE
    bus.pll_locked_async = 1'b1;
    restart();
    step(PRC + 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("t7");
    @(negedge clk);
    rst = 1'b0;
    step(30);
    chk("t7.rerun", 32'(bus.ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
